// File: rtl/ngc_fifo_pkg.sv
// ngc_fifo_pkg: shared definitions for the ngc_fifo stream blocks.
//   fsm_state_e  - reader phase (idle / fetching / draining)
//   FIFO_RD_LAT  - cycles from an accepted pop to valid fifo_dout
//   SKID_DEPTH   - entries in the reader's skid buffer
//   occ_of()     - words owned by the reader (buffered + in flight)
package ngc_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_state_e;

  localparam int FIFO_RD_LAT = 1;
  localparam int SKID_DEPTH  = 2;
  localparam int SKID_CNT_W  = $clog2(SKID_DEPTH + 1);
  localparam int OCC_W       = $clog2(SKID_DEPTH + FIFO_RD_LAT + 1);

  function automatic logic [OCC_W-1:0] occ_of(input logic [SKID_CNT_W-1:0] buf_cnt,
                                              input logic                  inflight);
    return OCC_W'(buf_cnt) + OCC_W'(inflight);
  endfunction

endpackage

// File: rtl/ngc_skid_buf.sv
// ngc_skid_buf: 2-entry in-order buffer.
//   clk, rst_n     - clock, asynchronous active-low reset
//   push/push_data - write one word behind the current contents
//   pop            - drop the head word (ignored when empty)
//   head           - oldest word (entry 0)
//   count          - number of valid entries (0..SKID_DEPTH)
module ngc_skid_buf
  import ngc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [SKID_CNT_W-1:0] count
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
  logic                  do_pop;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    do_pop = pop && (cnt_q != '0);
    if (do_pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 1'b1;
    end
    // The dequeue is applied first, so a simultaneous push lands directly
    // behind whatever word is left; order is preserved in every case.
    if (push && (cnt_d != SKID_CNT_W'(SKID_DEPTH))) begin
      if (cnt_d == '0) ent0_d = push_data;
      else             ent1_d = push_data;
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = ent0_q;
  assign count = cnt_q;

endmodule

// File: rtl/ngc_fifo_reader.sv
// ngc_fifo_reader: pop-side master of an ngc_fifo, presenting its contents
// as a full-throughput valid/ready stream.
//   clk, rst                   - clock, asynchronous active-low reset
//   en                         - allow new pops
//   fifo_pop                   - pop strobe to the FIFO (never while empty)
//   fifo_dout/empty/num        - FIFO read data (one cycle after pop), flags
//   m_valid/m_data/m_ready     - output stream
//   busy                       - words buffered or in flight
//   words_out                  - stream handshakes since reset (wrapping)
module ngc_fifo_reader
  import ngc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   fifo_pop,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  input  logic [$clog2(SIZE):0]  fifo_num,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   words_out
);

  localparam int LIM_W = OCC_W + 1;

  fsm_state_e           state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic                 armed_q, armed_d;
  logic [CNT_WIDTH-1:0] words_q, words_d;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic [OCC_W-1:0]     occ;
  logic                 deq;
  logic                 unused_fifo_num;

  // Occupancy is observed only; nothing in the read path depends on it.
  assign unused_fifo_num = ^fifo_num;

  ngc_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst),
    .push      (inflight_q),
    .push_data (fifo_dout),
    .pop       (deq),
    .head      (m_data),
    .count     (buf_cnt)
  );

  assign m_valid = (buf_cnt != '0);
  assign deq     = m_valid & m_ready;
  assign occ     = occ_of(buf_cnt, inflight_q);
  assign busy    = (occ != '0);

  // A pop is allowed when the word it fetches is guaranteed a slot: the
  // buffer plus the in-flight word, less any word leaving this cycle, must
  // stay below the skid depth. en gates fetching directly (not through the
  // FSM) so the first pop coincides with the edge that enters RUN.
  // armed_q drops asynchronously with rst, forcing fifo_pop low during reset.
  assign fifo_pop = armed_q & en & ~fifo_empty &
                    (LIM_W'(occ) < (LIM_W'(SKID_DEPTH) + LIM_W'(deq)));

  always_comb begin
    inflight_d = fifo_pop;
    armed_d    = 1'b1;
    words_d    = words_q + CNT_WIDTH'(deq);
    state_d    = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)                state_d = ST_RUN;
        else if (occ == '0)    state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      armed_q    <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      armed_q    <= armed_d;
      words_q    <= words_d;
    end
  end

  assign words_out = words_q;

endmodule
